// File: rtl/fifo.sv
// CAN receive message queue: filters each frame on new_ID, commits accepted frames on pkt_done, host pops the head.
// Head outputs are combinational (zero latency); when full a new frame overwrites the oldest entry or is dropped, per enable_overrun.
module fifo (
  input  logic        clk,
  input  logic        nRST,
  input  logic [28:0] ID,
  input  logic [7:0]  data,
  input  logic [3:0]  data_index,
  input  logic        load_data,
  input  logic [3:0]  pkt_size,
  input  logic        RTR,
  input  logic        EXT,
  input  logic        pkt_done,
  input  logic        enable_overrun,
  input  logic        new_ID,
  input  logic [19:0] mask_enable,
  input  logic [30:0] filter_0,
  input  logic [30:0] filter_1,
  input  logic [30:0] filter_2,
  input  logic [30:0] filter_3,
  input  logic [30:0] filter_4,
  input  logic [30:0] filter_5,
  input  logic [30:0] filter_6,
  input  logic [30:0] filter_7,
  input  logic [30:0] filter_8,
  input  logic [30:0] filter_9,
  input  logic [30:0] filter_10,
  input  logic [30:0] filter_11,
  input  logic [30:0] filter_12,
  input  logic [30:0] filter_13,
  input  logic [30:0] filter_14,
  input  logic [30:0] filter_15,
  input  logic [30:0] filter_16,
  input  logic [30:0] filter_17,
  input  logic [30:0] filter_18,
  input  logic [30:0] filter_19,
  input  logic [30:0] mask_0,
  input  logic [30:0] mask_1,
  input  logic [30:0] mask_2,
  input  logic [30:0] mask_3,
  input  logic [30:0] mask_4,
  input  logic [30:0] mask_5,
  input  logic [30:0] mask_6,
  input  logic [30:0] mask_7,
  input  logic [30:0] mask_8,
  input  logic [30:0] mask_9,
  input  logic [30:0] mask_10,
  input  logic [30:0] mask_11,
  input  logic [30:0] mask_12,
  input  logic [30:0] mask_13,
  input  logic [30:0] mask_14,
  input  logic [30:0] mask_15,
  input  logic [30:0] mask_16,
  input  logic [30:0] mask_17,
  input  logic [30:0] mask_18,
  input  logic [30:0] mask_19,
  input  logic        read_fifo,
  output logic [3:0]  occupancy,
  output logic        full,
  output logic        empty,
  output logic        overrun,
  output logic [31:0] data_L,
  output logic [31:0] data_H,
  output logic [28:0] ID_out,
  output logic [3:0]  pkt_size_out,
  output logic        RTR_out,
  output logic        EXT_out,
  output logic [4:0]  fmi_out,
  output logic        fifo_read
);

  localparam int DEPTH = 8;
  localparam int NFILT = 20;
  localparam int PW    = $clog2(DEPTH);

  logic [30:0] filt [NFILT];
  logic [30:0] msk  [NFILT];

  assign filt[0]  = filter_0;   assign msk[0]  = mask_0;
  assign filt[1]  = filter_1;   assign msk[1]  = mask_1;
  assign filt[2]  = filter_2;   assign msk[2]  = mask_2;
  assign filt[3]  = filter_3;   assign msk[3]  = mask_3;
  assign filt[4]  = filter_4;   assign msk[4]  = mask_4;
  assign filt[5]  = filter_5;   assign msk[5]  = mask_5;
  assign filt[6]  = filter_6;   assign msk[6]  = mask_6;
  assign filt[7]  = filter_7;   assign msk[7]  = mask_7;
  assign filt[8]  = filter_8;   assign msk[8]  = mask_8;
  assign filt[9]  = filter_9;   assign msk[9]  = mask_9;
  assign filt[10] = filter_10;  assign msk[10] = mask_10;
  assign filt[11] = filter_11;  assign msk[11] = mask_11;
  assign filt[12] = filter_12;  assign msk[12] = mask_12;
  assign filt[13] = filter_13;  assign msk[13] = mask_13;
  assign filt[14] = filter_14;  assign msk[14] = mask_14;
  assign filt[15] = filter_15;  assign msk[15] = mask_15;
  assign filt[16] = filter_16;  assign msk[16] = mask_16;
  assign filt[17] = filter_17;  assign msk[17] = mask_17;
  assign filt[18] = filter_18;  assign msk[18] = mask_18;
  assign filt[19] = filter_19;  assign msk[19] = mask_19;

  logic [30:0] key;
  logic        hit_any;
  logic [4:0]  hit_idx;

  assign key = {EXT, RTR, ID};

  // Scan from the top so the lowest hitting index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NFILT - 1; i >= 0; i--) begin
      if (mask_enable[i] && (((key ^ filt[i]) & msk[i]) == 31'd0)) begin
        hit_any = 1'b1;
        hit_idx = 5'(i);
      end
    end
  end

  // Staging buffer for the frame currently being received
  logic [28:0]     stg_id_q,   stg_id_d;
  logic            stg_rtr_q,  stg_rtr_d;
  logic            stg_ext_q,  stg_ext_d;
  logic [3:0]      stg_dlc_q,  stg_dlc_d;
  logic [7:0][7:0] stg_data_q, stg_data_d;
  logic            match_q,    match_d;
  logic [4:0]      fmi_q,      fmi_d;

  always_comb begin
    stg_id_d   = stg_id_q;
    stg_rtr_d  = stg_rtr_q;
    stg_ext_d  = stg_ext_q;
    stg_dlc_d  = stg_dlc_q;
    stg_data_d = stg_data_q;
    match_d    = match_q;
    fmi_d      = fmi_q;
    if (pkt_done) match_d = 1'b0;
    if (new_ID) begin
      stg_id_d   = ID;
      stg_rtr_d  = RTR;
      stg_ext_d  = EXT;
      stg_dlc_d  = (pkt_size > 4'd8) ? 4'd8 : pkt_size;
      stg_data_d = '0;
      match_d    = hit_any;
      fmi_d      = hit_idx;
    end
    if (load_data && !data_index[3]) stg_data_d[data_index[2:0]] = data;
  end

  // Queue pointers and status
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    occ_q, occ_d, occ_pop;
  logic          ovr_q, ovr_d;
  logic          fifo_read_q, fifo_read_d;
  logic          pop, commit, wr_en;

  // A same-cycle pop frees a slot before the commit looks at fullness.
  always_comb begin
    pop         = read_fifo && (occ_q != 4'd0);
    commit      = pkt_done && match_q;
    occ_pop     = occ_q - {3'b000, pop};
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_pop;
    ovr_d       = ovr_q;
    wr_en       = 1'b0;
    fifo_read_d = pop;
    if (pop) begin
      head_d = head_q + PW'(1);
      ovr_d  = 1'b0;
    end
    if (commit) begin
      if (occ_pop != 4'(DEPTH)) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PW'(1);
        occ_d  = occ_pop + 4'd1;
      end else begin
        ovr_d = 1'b1;
        if (enable_overrun) begin
          wr_en  = 1'b1;
          tail_d = tail_q + PW'(1);
          head_d = head_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      stg_id_q    <= '0;
      stg_rtr_q   <= 1'b0;
      stg_ext_q   <= 1'b0;
      stg_dlc_q   <= '0;
      stg_data_q  <= '0;
      match_q     <= 1'b0;
      fmi_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      ovr_q       <= 1'b0;
      fifo_read_q <= 1'b0;
    end else begin
      stg_id_q    <= stg_id_d;
      stg_rtr_q   <= stg_rtr_d;
      stg_ext_q   <= stg_ext_d;
      stg_dlc_q   <= stg_dlc_d;
      stg_data_q  <= stg_data_d;
      match_q     <= match_d;
      fmi_q       <= fmi_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      ovr_q       <= ovr_d;
      fifo_read_q <= fifo_read_d;
    end
  end

  // Message storage; contents are never read while empty, so no reset needed.
  logic [28:0]     mem_id   [DEPTH];
  logic            mem_rtr  [DEPTH];
  logic            mem_ext  [DEPTH];
  logic [3:0]      mem_dlc  [DEPTH];
  logic [4:0]      mem_fmi  [DEPTH];
  logic [7:0][7:0] mem_data [DEPTH];

  always_ff @(posedge clk) begin
    if (nRST && wr_en) begin
      mem_id[tail_q]   <= stg_id_q;
      mem_rtr[tail_q]  <= stg_rtr_q;
      mem_ext[tail_q]  <= stg_ext_q;
      mem_dlc[tail_q]  <= stg_dlc_q;
      mem_fmi[tail_q]  <= fmi_q;
      mem_data[tail_q] <= stg_data_q;
    end
  end

  logic [7:0][7:0] hd_bytes;

  always_comb begin
    hd_bytes     = '0;
    ID_out       = '0;
    pkt_size_out = '0;
    RTR_out      = 1'b0;
    EXT_out      = 1'b0;
    fmi_out      = '0;
    if (occ_q != 4'd0) begin
      ID_out       = mem_id[head_q];
      pkt_size_out = mem_dlc[head_q];
      RTR_out      = mem_rtr[head_q];
      EXT_out      = mem_ext[head_q];
      fmi_out      = mem_fmi[head_q];
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < mem_dlc[head_q]) hd_bytes[k] = mem_data[head_q][k];
      end
    end
  end

  assign data_L    = hd_bytes[3:0];
  assign data_H    = hd_bytes[7:4];
  assign occupancy = occ_q;
  assign full      = (occ_q == 4'(DEPTH));
  assign empty     = (occ_q == 4'd0);
  assign overrun   = ovr_q;
  assign fifo_read = fifo_read_q;

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the CAN receive FIFO; pops push the expected new head into a scoreboard checked on fifo_read.
module tb_fifo;

  logic        clk = 1'b0;
  logic        nRST;
  logic [28:0] ID;
  logic [7:0]  data;
  logic [3:0]  data_index;
  logic        load_data;
  logic [3:0]  pkt_size;
  logic        RTR, EXT, pkt_done, enable_overrun, new_ID, read_fifo;
  logic [19:0] mask_enable;
  logic [30:0] filt [20];
  logic [30:0] msk  [20];
  logic [3:0]  occupancy;
  logic        full, empty, overrun;
  logic [31:0] data_L, data_H;
  logic [28:0] ID_out;
  logic [3:0]  pkt_size_out;
  logic        RTR_out, EXT_out;
  logic [4:0]  fmi_out;
  logic        fifo_read;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  occ;
    logic [31:0] dl;
    logic [31:0] dh;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic        ext;
    logic [4:0]  fmi;
    logic        ovr;
  } exp_t;

  exp_t sb[$];

  localparam logic [28:0] ID596 = {11'h596, 18'h0};
  localparam logic [28:0] ID014 = {11'h014, 18'h0};
  localparam logic [28:0] ID194 = {11'h194, 18'h0};
  localparam logic [28:0] IDX1  = {11'h014, 18'b101100010101011101};
  localparam logic [28:0] IDX2  = {11'h014, 18'h00001};

  fifo dut (
    .clk(clk), .nRST(nRST), .ID(ID), .data(data), .data_index(data_index),
    .load_data(load_data), .pkt_size(pkt_size), .RTR(RTR), .EXT(EXT),
    .pkt_done(pkt_done), .enable_overrun(enable_overrun), .new_ID(new_ID),
    .mask_enable(mask_enable),
    .filter_0(filt[0]),   .filter_1(filt[1]),   .filter_2(filt[2]),   .filter_3(filt[3]),
    .filter_4(filt[4]),   .filter_5(filt[5]),   .filter_6(filt[6]),   .filter_7(filt[7]),
    .filter_8(filt[8]),   .filter_9(filt[9]),   .filter_10(filt[10]), .filter_11(filt[11]),
    .filter_12(filt[12]), .filter_13(filt[13]), .filter_14(filt[14]), .filter_15(filt[15]),
    .filter_16(filt[16]), .filter_17(filt[17]), .filter_18(filt[18]), .filter_19(filt[19]),
    .mask_0(msk[0]),   .mask_1(msk[1]),   .mask_2(msk[2]),   .mask_3(msk[3]),
    .mask_4(msk[4]),   .mask_5(msk[5]),   .mask_6(msk[6]),   .mask_7(msk[7]),
    .mask_8(msk[8]),   .mask_9(msk[9]),   .mask_10(msk[10]), .mask_11(msk[11]),
    .mask_12(msk[12]), .mask_13(msk[13]), .mask_14(msk[14]), .mask_15(msk[15]),
    .mask_16(msk[16]), .mask_17(msk[17]), .mask_18(msk[18]), .mask_19(msk[19]),
    .read_fifo(read_fifo), .occupancy(occupancy), .full(full), .empty(empty),
    .overrun(overrun), .data_L(data_L), .data_H(data_H), .ID_out(ID_out),
    .pkt_size_out(pkt_size_out), .RTR_out(RTR_out), .EXT_out(EXT_out),
    .fmi_out(fmi_out), .fifo_read(fifo_read)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] occ, input logic [31:0] dl, input logic [31:0] dh,
                              input logic [28:0] id, input logic [3:0] dlc, input logic ext,
                              input logic [4:0] fmi, input logic ovr);
    exp_t e;
    e.occ = occ; e.dl = dl; e.dh = dh; e.id = id;
    e.dlc = dlc; e.ext = ext; e.fmi = fmi; e.ovr = ovr;
    return e;
  endfunction

  task automatic check_head(input string tag, input exp_t e);
    chk({tag, ".occupancy"}, 64'(occupancy),    64'(e.occ));
    chk({tag, ".empty"},     64'(empty),        64'(e.occ == 4'd0));
    chk({tag, ".full"},      64'(full),         64'(e.occ == 4'd8));
    chk({tag, ".overrun"},   64'(overrun),      64'(e.ovr));
    chk({tag, ".data_L"},    64'(data_L),       64'(e.dl));
    chk({tag, ".data_H"},    64'(data_H),       64'(e.dh));
    chk({tag, ".ID_out"},    64'(ID_out),       64'(e.id));
    chk({tag, ".pkt_size"},  64'(pkt_size_out), 64'(e.dlc));
    chk({tag, ".RTR_out"},   64'(RTR_out),      64'd0);
    chk({tag, ".EXT_out"},   64'(EXT_out),      64'(e.ext));
    chk({tag, ".fmi_out"},   64'(fmi_out),      64'(e.fmi));
  endtask

  task automatic send_frame(input logic [28:0] id, input logic ext, input logic [3:0] psz,
                            input logic [63:0] bytes, input int nb, input logic bad8,
                            input logic pop_too);
    ID = id; EXT = ext; RTR = 1'b0; pkt_size = psz; new_ID = 1'b1;
    tick();
    new_ID = 1'b0;
    for (int k = 0; k < nb; k++) begin
      load_data = 1'b1; data_index = 4'(k); data = bytes[8*k +: 8];
      tick();
    end
    if (bad8) begin
      load_data = 1'b1; data_index = 4'd8; data = 8'hFF;
      tick();
    end
    load_data = 1'b0; pkt_done = 1'b1; read_fifo = pop_too;
    tick();
    pkt_done = 1'b0; read_fifo = 1'b0;
  endtask

  task automatic pop(input exp_t e);
    sb.push_back(e);
    read_fifo = 1'b1;
    tick();
    read_fifo = 1'b0;
    tick();
  endtask

  // Monitor: every fifo_read pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (nRST === 1'b1 && fifo_read === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fifo_read: got 1 expected 0");
      end else begin
        check_head("pop", sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; ID = '0; data = '0; data_index = '0; load_data = 1'b0;
    pkt_size = '0; RTR = 1'b0; EXT = 1'b0; pkt_done = 1'b0; enable_overrun = 1'b0;
    new_ID = 1'b0; read_fifo = 1'b0; mask_enable = 20'h000FF;
    for (int i = 0; i < 20; i++) begin
      filt[i] = '0;
      msk[i]  = (i < 8) ? {2'b00, 11'h7FF, 18'h0} : 31'h0;
    end
    filt[0] = {2'b00, ID596};
    filt[1] = {2'b00, ID014};

    repeat (3) tick();
    check_head("reset", mk(4'd0, 32'h0, 32'h0, 29'h0, 4'd0, 1'b0, 5'd0, 1'b0));
    chk("reset.fifo_read", 64'(fifo_read), 64'd0);
    nRST = 1'b1;
    tick();

    send_frame(ID596, 1'b0, 4'd2, 64'hADAC, 2, 1'b0, 1'b0);
    check_head("f1", mk(4'd1, 32'h0000ADAC, 32'h0, ID596, 4'd2, 1'b0, 5'd0, 1'b0));
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("repeat_done.occupancy", 64'(occupancy), 64'd1);

    send_frame(ID596, 1'b0, 4'd8,  64'hED3DAFA5_8DA9ADAC, 8, 1'b0, 1'b0);
    send_frame(ID596, 1'b0, 4'd2,  64'h2211,              2, 1'b0, 1'b0);
    send_frame(ID596, 1'b0, 4'd8,  64'h08070605_04030201, 8, 1'b0, 1'b0);
    send_frame(ID596, 1'b0, 4'd3,  64'h34333231,          4, 1'b0, 1'b0);
    send_frame(ID596, 1'b0, 4'd12, 64'h48474645_44434241, 8, 1'b0, 1'b0);
    send_frame(ID014, 1'b0, 4'd1,  64'h51,                1, 1'b1, 1'b0);
    send_frame(IDX1,  1'b1, 4'd1,  64'h61,                1, 1'b0, 1'b0);
    check_head("full8", mk(4'd8, 32'h0000ADAC, 32'h0, ID596, 4'd2, 1'b0, 5'd0, 1'b0));

    pop(mk(4'd7, 32'h8DA9ADAC, 32'hED3DAFA5, ID596, 4'd8, 1'b0, 5'd0, 1'b0));

    enable_overrun = 1'b1;
    send_frame(IDX2, 1'b1, 4'd1, 64'h71, 1, 1'b0, 1'b0);
    check_head("refill", mk(4'd8, 32'h8DA9ADAC, 32'hED3DAFA5, ID596, 4'd8, 1'b0, 5'd0, 1'b0));
    send_frame(IDX2, 1'b1, 4'd1, 64'h72, 1, 1'b0, 1'b0);
    check_head("overwrite", mk(4'd8, 32'h00002211, 32'h0, ID596, 4'd2, 1'b0, 5'd0, 1'b1));

    pop(mk(4'd7, 32'h04030201, 32'h08070605, ID596, 4'd8, 1'b0, 5'd0, 1'b0));
    send_frame(ID194, 1'b0, 4'd1, 64'hC1, 1, 1'b0, 1'b0);
    send_frame(ID194, 1'b0, 4'd1, 64'hC2, 1, 1'b0, 1'b0);
    check_head("nohit", mk(4'd7, 32'h04030201, 32'h08070605, ID596, 4'd8, 1'b0, 5'd0, 1'b0));

    send_frame(ID596, 1'b0, 4'd1, 64'h81, 1, 1'b0, 1'b0);
    enable_overrun = 1'b0;
    send_frame(ID596, 1'b0, 4'd1, 64'hEE, 1, 1'b0, 1'b0);
    check_head("drop", mk(4'd8, 32'h04030201, 32'h08070605, ID596, 4'd8, 1'b0, 5'd0, 1'b1));

    sb.push_back(mk(4'd8, 32'h00333231, 32'h0, ID596, 4'd3, 1'b0, 5'd0, 1'b0));
    send_frame(ID596, 1'b0, 4'd2, 64'h9291, 2, 1'b0, 1'b1);
    check_head("pop_commit", mk(4'd8, 32'h00333231, 32'h0, ID596, 4'd3, 1'b0, 5'd0, 1'b0));

    pop(mk(4'd7, 32'h44434241, 32'h48474645, ID596, 4'd8, 1'b0, 5'd0, 1'b0));
    pop(mk(4'd6, 32'h00000051, 32'h0, ID014, 4'd1, 1'b0, 5'd1, 1'b0));
    pop(mk(4'd5, 32'h00000061, 32'h0, IDX1,  4'd1, 1'b1, 5'd1, 1'b0));
    pop(mk(4'd4, 32'h00000071, 32'h0, IDX2,  4'd1, 1'b1, 5'd1, 1'b0));
    pop(mk(4'd3, 32'h00000072, 32'h0, IDX2,  4'd1, 1'b1, 5'd1, 1'b0));
    pop(mk(4'd2, 32'h00000081, 32'h0, ID596, 4'd1, 1'b0, 5'd0, 1'b0));
    pop(mk(4'd1, 32'h00009291, 32'h0, ID596, 4'd2, 1'b0, 5'd0, 1'b0));
    pop(mk(4'd0, 32'h0, 32'h0, 29'h0, 4'd0, 1'b0, 5'd0, 1'b0));

    read_fifo = 1'b1;
    tick();
    read_fifo = 1'b0;
    repeat (3) tick();
    check_head("empty_pop", mk(4'd0, 32'h0, 32'h0, 29'h0, 4'd0, 1'b0, 5'd0, 1'b0));
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
